// File: rtl/uart_sample_assembler.sv
// uart_sample_assembler
// Pairs consecutive UART bytes (low byte first) into 16-bit samples, drops an
// orphaned low byte after an inter-byte timeout, and buffers samples in a
// first-word-fall-through FIFO with a valid/ready output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT_LO | idle, next received byte is the low half of a sample
// WAIT_HI | low byte held, timeout running, next byte completes the sample
module uart_sample_assembler #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int TIMEOUT_BYTES   = 4,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                          clkIn,
   input  logic                          resetIn,
   input  logic                          byteValidIn,
   input  logic [7:0]                    byteDataIn,
   input  logic                          sampleReadyIn,
   input  logic                          clearErrIn,
   output logic [15:0]                   sampleOut,
   output logic                          sampleValidOut,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevelOut,
   output logic                          overflowErrOut,
   output logic                          resyncErrOut
);

   localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE * 10 * TIMEOUT_BYTES;
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W          = $clog2(FIFO_DEPTH);
   localparam int LVL_W          = PTR_W + 1;

   typedef enum logic {
      WAIT_LO = 1'b0,
      WAIT_HI = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         lo_q, lo_d;
   logic               push;
   logic [15:0]        push_data;
   logic               resync_evt;

   logic [15:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               pop, full, wr_en, ovf_evt;
   logic               ovf_q, resync_q;

   // Assembler next-state: a byte in WAIT_HI always beats timeout expiry.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lo_d       = lo_q;
      push       = 1'b0;
      push_data  = {byteDataIn, lo_q};
      resync_evt = 1'b0;
      case (state_q)
         WAIT_LO: begin
            if (byteValidIn) begin
               lo_d    = byteDataIn;
               cnt_d   = CNT_W'(TIMEOUT_CYCLES);
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (byteValidIn) begin
               push    = 1'b1;
               state_d = WAIT_LO;
            end else if (cnt_q == '0) begin
               resync_evt = 1'b1;
               lo_d       = 8'h00;
               state_d    = WAIT_LO;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = WAIT_LO;
      endcase
   end

   // Assembler state, timeout counter and held low byte.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         state_q <= WAIT_LO;
         cnt_q   <= '0;
         lo_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
      end
   end

   assign full    = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop     = sampleValidOut & sampleReadyIn;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en   = push & (~full | pop);
   assign ovf_evt = push & full & ~pop;

   // FIFO occupancy update.
   always_comb begin
      level_d = level_q;
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO pointers and level; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
      end
   end

   // Sample storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Sticky error flags; a set event wins over a coincident clear.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         ovf_q    <= 1'b0;
         resync_q <= 1'b0;
      end else begin
         if (ovf_evt)         ovf_q <= 1'b1;
         else if (clearErrIn) ovf_q <= 1'b0;
         if (resync_evt)      resync_q <= 1'b1;
         else if (clearErrIn) resync_q <= 1'b0;
      end
   end

   assign sampleOut      = mem_q[rd_ptr_q];
   assign sampleValidOut = (level_q != '0);
   assign fifoLevelOut   = level_q;
   assign overflowErrOut = ovf_q;
   assign resyncErrOut   = resync_q;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Bench for uart_sample_assembler: a queue model of the FIFO is fed whenever a
// high byte is driven and checked against the DUT output on every pop.
module tb_uart_sample_assembler;

   localparam int CLK_F   = 100_000;
   localparam int BAUD    = 10_000;
   localparam int TO_B    = 4;
   localparam int DEPTH   = 8;
   localparam int T_CYC   = CLK_F / BAUD * 10 * TO_B;

   logic        clkIn = 1'b0;
   logic        resetIn;
   logic        byteValidIn;
   logic [7:0]  byteDataIn;
   logic        sampleReadyIn;
   logic        clearErrIn;
   logic [15:0] sampleOut;
   logic        sampleValidOut;
   logic [$clog2(DEPTH):0] fifoLevelOut;
   logic        overflowErrOut;
   logic        resyncErrOut;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] model_q[$];
   bit          exp_push = 1'b0;
   logic [15:0] exp_data = 16'h0000;

   uart_sample_assembler #(
      .CLOCK_FREQUENCY(CLK_F),
      .BAUD_RATE(BAUD),
      .TIMEOUT_BYTES(TO_B),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clkIn(clkIn),
      .resetIn(resetIn),
      .byteValidIn(byteValidIn),
      .byteDataIn(byteDataIn),
      .sampleReadyIn(sampleReadyIn),
      .clearErrIn(clearErrIn),
      .sampleOut(sampleOut),
      .sampleValidOut(sampleValidOut),
      .fifoLevelOut(fifoLevelOut),
      .overflowErrOut(overflowErrOut),
      .resyncErrOut(resyncErrOut)
   );

   always #5 clkIn = ~clkIn;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clkIn);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b, input bit push, input logic [15:0] d);
      byteValidIn = 1'b1;
      byteDataIn  = b;
      exp_push    = push;
      exp_data    = d;
      tick();
      byteValidIn = 1'b0;
      exp_push    = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] lo, input logic [7:0] hi, input int gap);
      drive_byte(lo, 1'b0, 16'h0000);
      repeat (gap) tick();
      drive_byte(hi, 1'b1, {hi, lo});
   endtask

   // Scoreboard: compare occupancy every cycle and data on every pop.
   always @(negedge clkIn) begin
      bit pop;
      if (resetIn === 1'b1) begin
         model_q.delete();
      end else begin
         pop = (model_q.size() > 0) && (sampleReadyIn === 1'b1);
         check_eq("level", 32'(fifoLevelOut), 32'(model_q.size()));
         check_eq("valid", 32'(sampleValidOut), 32'(model_q.size() > 0));
         if (pop) begin
            check_eq("pop_data", 32'(sampleOut), 32'(model_q[0]));
            void'(model_q.pop_front());
         end
         if (exp_push && model_q.size() < DEPTH) model_q.push_back(exp_data);
      end
   end

   initial begin
      resetIn       = 1'b1;
      byteValidIn   = 1'b0;
      byteDataIn    = 8'h00;
      sampleReadyIn = 1'b0;
      clearErrIn    = 1'b0;
      repeat (3) tick();
      check_eq("rst_valid", 32'(sampleValidOut), 32'd0);
      check_eq("rst_level", 32'(fifoLevelOut), 32'd0);
      check_eq("rst_ovf", 32'(overflowErrOut), 32'd0);
      check_eq("rst_resync", 32'(resyncErrOut), 32'd0);
      check_eq("rst_sample", 32'(sampleOut), 32'd0);
      resetIn = 1'b0;
      tick();

      // Basic pair with consumer ready.
      sampleReadyIn = 1'b1;
      send_pair(8'h34, 8'h12, 0);
      check_eq("pair_valid", 32'(sampleValidOut), 32'd1);
      check_eq("pair_data", 32'(sampleOut), 32'h1234);
      tick();
      check_eq("pair_gone", 32'(sampleValidOut), 32'd0);
      check_eq("pair_level", 32'(fifoLevelOut), 32'd0);

      // Orphaned low byte times out; counter hits zero T cycles after load.
      drive_byte(8'hAA, 1'b0, 16'h0000);
      repeat (T_CYC) tick();
      check_eq("resync_early", 32'(resyncErrOut), 32'd0);
      tick();
      check_eq("resync_set", 32'(resyncErrOut), 32'd1);
      repeat (3) tick();
      send_pair(8'h78, 8'h56, 0);
      check_eq("resync_pair", 32'(sampleOut), 32'h5678);
      repeat (3) tick();
      clearErrIn = 1'b1;
      tick();
      clearErrIn = 1'b0;
      check_eq("resync_clr", 32'(resyncErrOut), 32'd0);

      // High byte on the exact expiry cycle wins over the timeout.
      send_pair(8'h22, 8'h33, T_CYC);
      check_eq("edge_data", 32'(sampleOut), 32'h3322);
      repeat (3) tick();
      check_eq("edge_resync", 32'(resyncErrOut), 32'd0);

      // Overflow: nine samples into eight slots with the consumer stalled.
      sampleReadyIn = 1'b0;
      for (int i = 0; i < 9; i++) send_pair(8'(i), 8'(8'h40 + i), 0);
      check_eq("ovf_level", 32'(fifoLevelOut), 32'd8);
      check_eq("ovf_flag", 32'(overflowErrOut), 32'd1);
      sampleReadyIn = 1'b1;
      repeat (10) tick();
      check_eq("ovf_drained", 32'(fifoLevelOut), 32'd0);
      clearErrIn = 1'b1;
      tick();
      clearErrIn = 1'b0;
      check_eq("ovf_clr", 32'(overflowErrOut), 32'd0);

      // Full FIFO with push and pop in the same cycle.
      sampleReadyIn = 1'b0;
      for (int i = 0; i < 8; i++) send_pair(8'(8'h80 + i), 8'(8'h90 + i), 0);
      check_eq("full_level", 32'(fifoLevelOut), 32'd8);
      drive_byte(8'hC0, 1'b0, 16'h0000);
      sampleReadyIn = 1'b1;
      drive_byte(8'hC1, 1'b1, 16'hC1C0);
      check_eq("pp_level", 32'(fifoLevelOut), 32'd8);
      check_eq("pp_ovf", 32'(overflowErrOut), 32'd0);
      repeat (10) tick();
      check_eq("pp_drained", 32'(fifoLevelOut), 32'd0);

      // Reset mid-pair and mid-transfer with errors set.
      sampleReadyIn = 1'b0;
      for (int i = 0; i < 9; i++) send_pair(8'(8'h10 + i), 8'(8'h20 + i), 0);
      drive_byte(8'hAA, 1'b0, 16'h0000);
      repeat (T_CYC + 3) tick();
      check_eq("pre_rst_ovf", 32'(overflowErrOut), 32'd1);
      check_eq("pre_rst_resync", 32'(resyncErrOut), 32'd1);
      drive_byte(8'h99, 1'b0, 16'h0000);
      resetIn = 1'b1;
      tick();
      check_eq("mid_rst_valid", 32'(sampleValidOut), 32'd0);
      check_eq("mid_rst_level", 32'(fifoLevelOut), 32'd0);
      check_eq("mid_rst_ovf", 32'(overflowErrOut), 32'd0);
      check_eq("mid_rst_resync", 32'(resyncErrOut), 32'd0);
      check_eq("mid_rst_sample", 32'(sampleOut), 32'd0);
      resetIn = 1'b0;
      tick();
      sampleReadyIn = 1'b1;
      send_pair(8'h01, 8'h80, 0);
      check_eq("post_rst_data", 32'(sampleOut), 32'h8001);
      tick();

      // Clear coinciding with an overflow event: the set wins.
      sampleReadyIn = 1'b0;
      for (int i = 0; i < 8; i++) send_pair(8'(8'h50 + i), 8'(8'h60 + i), 0);
      drive_byte(8'hE0, 1'b0, 16'h0000);
      clearErrIn = 1'b1;
      drive_byte(8'hE1, 1'b1, 16'hE1E0);
      clearErrIn = 1'b0;
      check_eq("clr_vs_set", 32'(overflowErrOut), 32'd1);
      sampleReadyIn = 1'b1;
      repeat (12) tick();
      check_eq("final_level", 32'(fifoLevelOut), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
